example_adder_pipe: RTL
=======================

// Module: example_adder_pipe
// PURPOSE
//  Multi-lane, elastic, pipelined successor to the single-stage incrementer.
//  Adds a per-transaction increment to LANES packed operands and carries the results through
//  PIPE_DEPTH registered stages with valid/ready backpressure.
//  Optional saturation and per-lane overflow flags. Sits between the bfm driver side and the
//  monitor side of the example testbench.
// PARAMETERS
//  DATA_WIDTH  8  width of each lane operand, increment and result
//  LANES       4  number of independent lanes packed per transaction
//  PIPE_DEPTH  3  registered stages input->output; legal range 1..16
//  SATURATE    0  0: wrap modulo 2^DATA_WIDTH; 1: clamp each lane result to 2^DATA_WIDTH-1
// PORTS
//  clk_i    in   1                 clock, all logic on rising edge
//  rst_i    in   1                 reset, synchronous, active-high
//  a_i      in   LANES*DATA_WIDTH  operands; lane k = a_i[k*DATA_WIDTH +: DATA_WIDTH]
//  inc_i    in   DATA_WIDTH        unsigned increment, applied to every lane of the beat
//  valid_i  in   1                 input beat valid
//  ready_o  out  1                 block can accept a beat this cycle
//  d_o      out  LANES*DATA_WIDTH  results, same lane packing as a_i
//  ovf_o    out  LANES             per-lane carry-out of the add (set in both modes)
//  valid_o  out  1                 output beat valid
//  ready_i  in   1                 downstream accepts output beat
// BEHAVIOUR
//  - Handshake: a beat transfers on a cycle with valid && ready at that boundary.
//    Upstream holds a_i/inc_i/valid_i stable until accepted. Outputs are held stable while
//    valid_o && !ready_i.
//  - Arithmetic: per lane, sum = {1'b0,a} + {1'b0,inc} (DATA_WIDTH+1 bits); ovf = sum[MSB].
//    Wrap mode: d = sum[DATA_WIDTH-1:0]. Saturate mode: d = ovf ? all-ones : sum[DATA_WIDTH-1:0].
//    Lanes are fully independent; no carry between lanes.
//  - Compute happens combinationally at the input and is registered into stage 0.
//    Stages 1..PIPE_DEPTH-1 only move data.
//  - Pipeline: stage s holds {v[s], d[s], ovf[s]}. adv[last] = ready_i. adv[s] = !v[s+1] || adv[s+1].
//    Stage s loads on (!v[s] || adv[s]). Bubbles collapse: an empty stage always accepts.
//  - ready_o = (!v[0] || adv[0]) && !rst_i. Full throughput: one beat per cycle with ready_i held at 1.
//  - Latency: a beat accepted at edge N appears on valid_o/d_o after edge N+PIPE_DEPTH-1,
//    i.e. PIPE_DEPTH cycles from the valid_i cycle, when there is no backpressure.
//  - Full: all PIPE_DEPTH stages valid and ready_i=0 -> ready_o=0. No beat is dropped or duplicated.
//  - Simultaneous accept and emit when full: when ready_i=1, ready_o=1 in the same cycle.
//    The pipeline shifts, and the count stays full.
//  - Data register contents of invalid stages are don't-care, but must not reach the outputs while valid_o=0.
//  - Ordering: beats leave strictly in acceptance order.
//  - Reset (synchronous, at any time, including mid-stream): all v[] <= 0, d[] <= 0, ovf[] <= 0.
//    In-flight beats are discarded. While rst_i=1, ready_o=0.
//    In the first cycle after rst_i falls: valid_o=0, d_o=0, ovf_o=0, ready_o=1.
//  - Reset values: ready_o=0 during reset; valid_o=0, d_o=0, ovf_o=0.
// TESTING
//  1. Defaults; one beat a=0x04_03_02_01, inc=1, ready_i=1 -> 3 cycles later one cycle of
//     valid_o with d_o=0x05_04_03_02 and ovf_o=0000.
//  2. Wrap, lane0 a=0xFF, inc=0x02 -> d lane0=0x01, ovf_o[0]=1. Same beat with SATURATE=1 ->
//     d lane0=0xFF, ovf_o[0]=1. Other lanes are unaffected.
//  3. Stream 32 beats back-to-back with ready_i=1 -> ready_o stays 1, 32 outputs on consecutive
//     cycles, in order, each matching the golden model.
//  4. Hold ready_i=0 with valid_i=1 -> exactly PIPE_DEPTH beats are accepted, then ready_o=0 and
//     d_o stays frozen. Release ready_i -> all beats drain in order; none lost or duplicated.
//  5. Random valid_i and ready_i (50%) over 1000 beats -> scoreboard shows zero mismatches and
//     zero count mismatch.
//  6. Assert rst_i for 1 cycle while the pipeline is full -> next cycle valid_o=0, d_o=0,
//     ovf_o=0, ready_o=1. No pre-reset beat ever emerges.

Source files
------------

// File: rtl/example_adder_pipe.sv
// example_adder_pipe
//   Multi-lane elastic incrementer. Each accepted beat carries LANES packed
//   operands plus one shared increment; every lane is added independently
//   (optionally saturating), and the result travels through PIPE_DEPTH
//   registered stages under valid/ready flow control.
//
// Parameters
//   DATA_WIDTH  lane operand / increment / result width
//   LANES       lanes packed per beat
//   PIPE_DEPTH  registered stages input->output (1..16)
//   SATURATE    0: wrap modulo 2^DATA_WIDTH, 1: clamp lane result to all-ones
//
// Ports
//   clk_i    rising-edge clock
//   rst_i    synchronous active-high reset; flushes all in-flight beats
//   a_i      packed operands, lane k = a_i[k*DATA_WIDTH +: DATA_WIDTH]
//   inc_i    unsigned increment applied to every lane of the beat
//   valid_i  input beat valid
//   ready_o  block accepts a beat this cycle (held low during reset)
//   d_o      packed results, same lane packing as a_i (zero while valid_o=0)
//   ovf_o    per-lane carry-out of the add (zero while valid_o=0)
//   valid_o  output beat valid
//   ready_i  downstream accepts the output beat
module example_adder_pipe #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 4,
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned SATURATE   = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [LANES*DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0]       inc_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic [LANES*DATA_WIDTH-1:0] d_o,
    output logic [LANES-1:0]            ovf_o,
    output logic                        valid_o,
    input  logic                        ready_i
);

    localparam int unsigned W    = LANES * DATA_WIDTH;
    localparam int unsigned LAST = PIPE_DEPTH - 1;

    logic [W-1:0]          sum_d;
    logic [LANES-1:0]      sum_ovf;
    logic [DATA_WIDTH:0]   lane_sum;

    logic [PIPE_DEPTH-1:0] v;
    logic [PIPE_DEPTH-1:0] load;
    logic                  chain;
    logic [W-1:0]          d_q   [PIPE_DEPTH];
    logic [LANES-1:0]      ovf_q [PIPE_DEPTH];

    // Per-lane add with one spare bit for the carry-out.
    always_comb begin
        sum_d    = '0;
        sum_ovf  = '0;
        lane_sum = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            lane_sum   = {1'b0, a_i[k*DATA_WIDTH +: DATA_WIDTH]} + {1'b0, inc_i};
            sum_ovf[k] = lane_sum[DATA_WIDTH];
            if ((SATURATE != 0) && lane_sum[DATA_WIDTH])
                sum_d[k*DATA_WIDTH +: DATA_WIDTH] = '1;
            else
                sum_d[k*DATA_WIDTH +: DATA_WIDTH] = lane_sum[DATA_WIDTH-1:0];
        end
    end

    // Load enables, walked from the output stage backwards: a stage may load
    // when it is empty or when everything downstream of it is moving. The
    // running term is kept in a local so the vector is never read back.
    always_comb begin
        load  = '0;
        chain = ready_i;
        for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
            chain            = !v[LAST-i] || chain;
            load[LAST-i]     = chain;
        end
    end

    assign ready_o = load[0] && !rst_i;

    // Data registers only capture real beats, so an emptied stage keeps
    // stale contents; the output gating below keeps those off d_o/ovf_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v <= '0;
            for (int unsigned s = 0; s < PIPE_DEPTH; s++) begin
                d_q[s]   <= '0;
                ovf_q[s] <= '0;
            end
        end else begin
            if (load[0]) begin
                v[0] <= valid_i;
                if (valid_i) begin
                    d_q[0]   <= sum_d;
                    ovf_q[0] <= sum_ovf;
                end
            end
            for (int unsigned s = 1; s < PIPE_DEPTH; s++) begin
                if (load[s]) begin
                    v[s] <= v[s-1];
                    if (v[s-1]) begin
                        d_q[s]   <= d_q[s-1];
                        ovf_q[s] <= ovf_q[s-1];
                    end
                end
            end
        end
    end

    assign valid_o = v[LAST];
    assign d_o     = v[LAST] ? d_q[LAST]   : '0;
    assign ovf_o   = v[LAST] ? ovf_q[LAST] : '0;

endmodule
